// File: rtl/booth_mult_4.sv
// booth_mult_4: sequential radix-2 Booth multiplier, 4x4 signed -> 8-bit signed product
module booth_mult_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  a_q, a_d, m_q, m_d;
  logic [3:0]  qr_q, qr_d;
  logic        q1_q, q1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  prod_q, prod_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        sub, add;
  logic [4:0]  addend, a_sum;
  logic [9:0]  shifted;
  // Subtraction is A + ~M + 1; the 5-bit width keeps -(-8) representable.
  assign sub     = qr_q[0] & ~q1_q;
  assign add     = ~qr_q[0] & q1_q;
  assign addend  = sub ? ~m_q : add ? m_q : 5'd0;
  assign a_sum   = a_q + addend + {4'd0, sub};
  assign shifted = {a_sum[4], a_sum, qr_q};
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    qr_d    = qr_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    if (state_q == IDLE && start) begin
      state_d = CALC;
      a_d     = 5'd0;
      qr_d    = multiplier;
      q1_d    = 1'b0;
      m_d     = {multiplicand[3], multiplicand};
      cnt_d   = 2'd0;
    end else if (state_q == CALC) begin
      a_d     = shifted[9:5];
      qr_d    = shifted[4:1];
      q1_d    = shifted[0];
      cnt_d   = cnt_q + 2'd1;
      state_d = (cnt_q == 2'd3) ? DONE : CALC;
      prod_d  = (cnt_q == 2'd3) ? shifted[8:1] : prod_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == CALC;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      qr_q    <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      qr_q    <= qr_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;
endmodule

// File: tb/tb_booth_mult_4.sv
// tb_booth_mult_4: directed vector table, exhaustive sweep and multi-cycle corner sequences
module tb_booth_mult_4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] multiplicand = '0;
  logic [3:0] multiplier = '0;
  logic       busy, done;
  logic [7:0] product;
  int vectors = 0;
  int errs = 0;

  booth_mult_4 dut (
    .clk(clk), .rst(rst), .start(start), .multiplicand(multiplicand),
    .multiplier(multiplier), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] p;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp, input bit full);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      multiplicand = 4'($urandom);
      multiplier   = 4'($urandom);
      if (full) begin
        chk("busy_calc", 8'(busy), 8'd1);
        chk("done_calc", 8'(done), 8'd0);
      end
      tick();
    end
    chk("done_pulse", 8'(done), 8'd1);
    if (full) chk("busy_done", 8'(busy), 8'd0);
    chk($sformatf("product %h*%h", m, q), product, exp);
    tick();
    if (full) begin
      chk("done_low", 8'(done), 8'd0);
      chk("product_hold", product, exp);
    end
  endtask

  initial begin
    vec_t vt[12];
    logic signed [3:0] ms4, qs4;
    int pi;
    vt[0]  = '{4'h3, 4'h5, 8'h0F};
    vt[1]  = '{4'h8, 4'h8, 8'h40};
    vt[2]  = '{4'h8, 4'h7, 8'hC8};
    vt[3]  = '{4'h0, 4'hF, 8'h00};
    vt[4]  = '{4'h2, 4'h3, 8'h06};
    vt[5]  = '{4'hF, 4'hF, 8'h01};
    vt[6]  = '{4'h7, 4'h7, 8'h31};
    vt[7]  = '{4'hF, 4'h1, 8'hFF};
    vt[8]  = '{4'h5, 4'hD, 8'hF1};
    vt[9]  = '{4'h4, 4'hC, 8'hF0};
    vt[10] = '{4'h7, 4'h8, 8'hC8};
    vt[11] = '{4'h1, 4'h1, 8'h01};

    tick();
    tick();
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_product", product, 8'h00);
    rst = 1'b0;
    tick();
    chk("idle_done", 8'(done), 8'd0);

    foreach (vt[i]) run_op(vt[i].m, vt[i].q, vt[i].p, 1'b1);

    for (int mi = 0; mi < 16; mi++)
      for (int qi = 0; qi < 16; qi++) begin
        ms4 = mi[3:0];
        qs4 = qi[3:0];
        pi  = ms4 * qs4;
        run_op(mi[3:0], qi[3:0], pi[7:0], 1'b0);
      end

    // start held high: operands only matter on the accepting IDLE edge
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      multiplicand = vt[i + 4].m;
      multiplier   = vt[i + 4].q;
      tick();
      for (int c = 0; c < 4; c++) begin
        chk("b2b_busy", 8'(busy), 8'd1);
        multiplicand = 4'($urandom);
        multiplier   = 4'($urandom);
        tick();
      end
      chk("b2b_done", 8'(done), 8'd1);
      chk("b2b_product", product, vt[i + 4].p);
      multiplicand = 4'($urandom);
      multiplier   = 4'($urandom);
      tick();
      chk("b2b_idle_busy", 8'(busy), 8'd0);
      chk("b2b_idle_done", 8'(done), 8'd0);
    end
    start = 1'b0;
    tick();

    // abort in the second CALC cycle
    multiplicand = 4'h7;
    multiplier   = 4'h7;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_busy_pre", 8'(busy), 8'd1);
    rst = 1'b1;
    tick();
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    chk("abort_product", product, 8'h00);
    rst = 1'b0;
    run_op(4'h7, 4'h7, 8'h31, 1'b1);
    for (int c = 0; c < 6; c++) begin
      chk("no_spurious_done", 8'(done), 8'd0);
      tick();
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_op(4'h2, 4'h3, 8'h06, 1'b1);
    run_op(4'hF, 4'hF, 8'h01, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
